// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and arbiter state encoding for the VGA
// scan-out / pixel-writer port sharing logic.
package fb_pkg;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_DEPTH = 76800;
  localparam int unsigned SCALE_SH = 1;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned H_LAST   = 639;

  typedef enum logic [1:0] {
    S_DISP  = 2'd0,
    S_BLANK = 2'd1,
    S_WR    = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_scan_addr.sv
// Display address generator: tracks the frame-buffer line base without a
// multiplier and adds the horizontally downscaled pixel offset.
module fb_scan_addr
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
  parameter int unsigned FB_W     = fb_pkg::FB_W,
  parameter int unsigned SCALE_SH = fb_pkg::SCALE_SH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  output logic [ADDR_W-1:0] disp_addr
);

  localparam logic [9:0] V_MASK = 10'((1 << SCALE_SH) - 1);

  logic [ADDR_W-1:0] line_base;
  logic              frame_start;
  logic              line_end;

  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign line_end    = valid && (h_cnt == 10'(H_LAST)) && ((v_cnt & V_MASK) == V_MASK);

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      line_base <= '0;
    end else if (line_end) begin
      line_base <= line_base + ADDR_W'(FB_W);
    end
  end

  // Pixel (0,0) is itself active, so the base is forced to zero combinationally
  // there; the register only clears on the following edge.
  assign disp_addr = (frame_start ? '0 : line_base) + ADDR_W'(h_cnt >> SCALE_SH);

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scan-out owns the BRAM during active video,
// the pixel writer is served in blanking; RGB is blanked and pipeline-aligned.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
  parameter int unsigned DATA_W   = fb_pkg::DATA_W,
  parameter int unsigned FB_W     = fb_pkg::FB_W,
  parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int unsigned SCALE_SH = fb_pkg::SCALE_SH,
  parameter int unsigned RD_LAT   = fb_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] rgb,
  output logic              rgb_valid,
  output logic              wr_err
);

  fb_state_e         state, state_next;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_din_next;
  logic              mem_we_next;
  logic              wr_err_next;
  logic              wr_fire;
  logic              wr_oob;
  logic [RD_LAT:0]   vld_dly;

  fb_scan_addr #(
    .ADDR_W   (ADDR_W),
    .FB_W     (FB_W),
    .SCALE_SH (SCALE_SH)
  ) u_scan_addr (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .valid     (valid),
    .disp_addr (disp_addr)
  );

  assign wr_ready = ~rst & ~valid;
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_oob   = 32'(wr_addr) >= FB_DEPTH;

  always_comb begin
    state_next    = state;
    mem_addr_next = mem_addr;
    mem_din_next  = mem_din;
    mem_we_next   = 1'b0;
    wr_err_next   = wr_err;

    // Port ownership follows valid directly so the first blanking cycle can
    // already accept a write, whatever state the FSM is leaving.
    if (valid) begin
      mem_addr_next = disp_addr;
    end else if (wr_fire) begin
      if (wr_oob) begin
        wr_err_next = 1'b1;
      end else begin
        mem_addr_next = wr_addr;
        mem_din_next  = wr_data;
        mem_we_next   = 1'b1;
      end
    end

    unique case (state)
      S_DISP:        state_next = valid ? S_DISP : S_BLANK;
      S_BLANK, S_WR: state_next = valid ? S_DISP : (wr_valid ? S_WR : S_BLANK);
      default:       state_next = S_DISP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_DISP;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      wr_err   <= 1'b0;
      vld_dly  <= '0;
    end else begin
      state    <= state_next;
      mem_addr <= mem_addr_next;
      mem_din  <= mem_din_next;
      mem_we   <= mem_we_next;
      wr_err   <= wr_err_next;
      vld_dly  <= (RD_LAT + 1)'({vld_dly, valid});
    end
  end

  assign rgb_valid = vld_dly[RD_LAT];
  assign rgb       = rgb_valid ? mem_dout : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a one-cycle-latency BRAM model.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_din;
  logic [11:0] mem_dout;
  logic [11:0] rgb;
  logic        rgb_valid;
  logic        wr_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic        rdy_s;
  logic [11:0] exp_rgb;
  logic        exp_rv;

  logic [11:0] bram [0:76799];

  fb_port_arbiter #(
    .ADDR_W   (17),
    .DATA_W   (12),
    .FB_W     (320),
    .FB_DEPTH (76800),
    .SCALE_SH (1),
    .RD_LAT   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .valid     (valid),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .rgb       (rgb),
    .rgb_valid (rgb_valid),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 17'd76800) bram[mem_addr] <= mem_din;
    mem_dout <= (mem_addr < 17'd76800) ? bram[mem_addr] : 12'h000;
  end

  function automatic logic [11:0] pix(input int unsigned a);
    return 12'(a * 7 + 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [9:0] h, input logic [9:0] v, input logic vl,
                     input logic wv, input logic [16:0] wa, input logic [11:0] wd);
    rst = r; h_cnt = h; v_cnt = v; valid = vl;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1 rdy_s = wr_ready;
    @(posedge clk);
    #1;
  endtask

  // rgb seen after this call belongs to the pixel driven one call earlier.
  task automatic scan_px(input int h, input int v, input logic vl);
    int unsigned ea;
    ea = 32'(v >> 1) * 320 + 32'(h >> 1);
    cyc(1'b0, 10'(h), 10'(v), vl, 1'b0, '0, '0);
    check("rgb", 32'(rgb), 32'(exp_rgb));
    check("rgb_valid", 32'(rgb_valid), 32'(exp_rv));
    if (vl) check("scan_addr", 32'(mem_addr), ea);
    if (h == 2 && v == 3) check("addr_2_3", 32'(mem_addr), 321);
    if (h == 639 && v == 479) check("addr_639_479", 32'(mem_addr), 76799);
    exp_rgb = vl ? pix(ea) : 12'h000;
    exp_rv  = vl;
  endtask

  initial begin
    int next_i, pulses, exp_wa;
    for (int i = 0; i < 76800; i++) bram[i] = pix(i);

    // Reset mid-frame with a pending write request
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'd100, 10'd50, 1'b1, 1'b1, 17'd5, 12'hfff);
    check("rst_wr_ready", 32'(rdy_s), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_din", 32'(mem_din), 0);
    check("rst_rgb", 32'(rgb), 0);
    check("rst_rgb_valid", 32'(rgb_valid), 0);
    check("rst_wr_err", 32'(wr_err), 0);

    // Frame walk: full lines at top and bottom, shortened lines elsewhere
    exp_rgb = 12'h000;
    exp_rv  = 1'b0;
    for (int v = 0; v < 480; v++) begin
      if (v < 4 || v == 479) begin
        for (int h = 0; h < 640; h++) scan_px(h, v, 1'b1);
      end else begin
        for (int h = 0; h < 3; h++) scan_px(h, v, 1'b1);
        scan_px(639, v, 1'b1);
      end
      scan_px(640, v, 1'b0);
      scan_px(641, v, 1'b0);
      if (v == 0) check("scan_first_addr_we", 32'(mem_we), 0);
    end
    // Next frame restarts at address 0 on pixel (0,0)
    scan_px(0, 0, 1'b1);
    scan_px(1, 0, 1'b1);
    scan_px(2, 0, 1'b1);
    scan_px(640, 0, 1'b0);

    // Collision: writer waits through active video
    for (int h = 3; h < 8; h++) begin
      cyc(1'b0, 10'(h), 10'd0, 1'b1, 1'b1, 17'd100, 12'habc);
      check("coll_ready", 32'(rdy_s), 0);
      check("coll_we", 32'(mem_we), 0);
    end
    cyc(1'b0, 10'd640, 10'd0, 1'b0, 1'b1, 17'd100, 12'habc);
    check("coll_ready_blank", 32'(rdy_s), 1);
    check("coll_we_blank", 32'(mem_we), 1);
    check("coll_addr", 32'(mem_addr), 100);
    check("coll_din", 32'(mem_din), 32'h abc);
    cyc(1'b0, 10'd641, 10'd0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("coll_we_once", 32'(mem_we), 0);
    check("coll_addr_hold", 32'(mem_addr), 100);

    // Burst of 50 writes interrupted by 10 active cycles
    next_i = 0; pulses = 0; exp_wa = 1000;
    for (int c = 0; c < 200 && next_i < 50; c++) begin
      logic vl;
      vl = (c >= 30 && c < 40);
      cyc(1'b0, vl ? 10'(c - 30) : 10'd650, 10'd1, vl, 1'b1, 17'(1000 + next_i), 12'(12'h100 + next_i));
      if (rdy_s) next_i++;
      if (c == 30) check("burst_pause_cnt", 32'(pulses), 30);
      if (vl) check("burst_stall_we", 32'(mem_we), 0);
      if (mem_we) begin
        check("burst_addr", 32'(mem_addr), 32'(exp_wa));
        check("burst_din", 32'(mem_din), 32'(12'h100 + exp_wa - 1000));
        exp_wa++;
        pulses++;
      end
    end
    check("burst_accepts", 32'(next_i), 50);
    check("burst_pulses", 32'(pulses), 50);
    cyc(1'b0, 10'd650, 10'd1, 1'b0, 1'b0, 17'd0, 12'h000);
    check("burst_idle_we", 32'(mem_we), 0);

    // Out-of-range write sets sticky error, boundary address still writes
    cyc(1'b0, 10'd650, 10'd2, 1'b0, 1'b1, 17'd76800, 12'h555);
    check("oob_ready", 32'(rdy_s), 1);
    check("oob_we", 32'(mem_we), 0);
    check("oob_err", 32'(wr_err), 1);
    cyc(1'b0, 10'd651, 10'd2, 1'b0, 1'b0, 17'd0, 12'h000);
    cyc(1'b0, 10'd0, 10'd3, 1'b1, 1'b0, 17'd0, 12'h000);
    check("oob_err_sticky", 32'(wr_err), 1);
    cyc(1'b0, 10'd650, 10'd3, 1'b0, 1'b1, 17'd76799, 12'h777);
    check("last_we", 32'(mem_we), 1);
    check("last_addr", 32'(mem_addr), 76799);
    check("last_err", 32'(wr_err), 1);

    // Reset on the cycle a write would be accepted
    cyc(1'b1, 10'd650, 10'd3, 1'b0, 1'b1, 17'd200, 12'h222);
    check("rstwr_ready", 32'(rdy_s), 0);
    check("rstwr_we", 32'(mem_we), 0);
    check("rstwr_err", 32'(wr_err), 0);
    check("rstwr_addr", 32'(mem_addr), 0);
    check("rstwr_rgb", 32'(rgb), 0);
    cyc(1'b0, 10'd651, 10'd3, 1'b0, 1'b0, 17'd0, 12'h000);
    check("rstwr_we_after", 32'(mem_we), 0);
    check("rstwr_err_after", 32'(wr_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
